memory_read_split: RTL and testbench

MEMORY_READ_SPLIT -- requirements
Module: memory_read_split

---
 rtl/memory_read_split_pkg.sv | 30 +++
 rtl/memory_read_merge.sv | 34 +++
 rtl/memory_read_split.sv | 193 +++++++++++++++++++
 tb/tb_memory_read_split.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_read_split_pkg.sv
// Shared definitions for the memory read splitter.
//   state_t      : splitter FSM encoding
//   split_len1   : bytes of an access that fit before the next line boundary
//   split_addr2  : start address of the line following the access start
package memory_read_split_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SINGLE = 3'd1,
        ST_FIRST  = 3'd2,
        ST_SECOND = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // line_bytes must be a power of two so the mask gives address mod line.
    function automatic logic [31:0] split_len1(input logic [31:0] addr,
                                               input logic [31:0] len,
                                               input logic [31:0] line_bytes);
        logic [31:0] left;
        left = line_bytes - (addr & (line_bytes - 32'd1));
        return (len < left) ? len : left;
    endfunction

    // Wraps modulo 2^32 through natural 32-bit overflow.
    function automatic logic [31:0] split_addr2(input logic [31:0] addr,
                                                input logic [31:0] line_bytes);
        return (addr & ~(line_bytes - 32'd1)) + line_bytes;
    endfunction

endpackage

// File: rtl/memory_read_merge.sv
// Combinational byte merge of up to two read pieces.
//   lo_data/lo_len : first piece, its low lo_len bytes land at byte 0
//   hi_data        : second piece, its low bytes land directly above lo_len
//   total_len      : bytes kept in total; everything above is zero-filled
//   merged         : little-endian assembled result
module memory_read_merge
    import memory_read_split_pkg::*;
#(
    parameter int MAX_LEN = 8,
    localparam int DATA_W = 8 * MAX_LEN,
    localparam int LW     = $clog2(MAX_LEN) + 1
) (
    input  logic [DATA_W-1:0] lo_data,
    input  logic [LW-1:0]     lo_len,
    input  logic [DATA_W-1:0] hi_data,
    input  logic [LW-1:0]     total_len,
    output logic [DATA_W-1:0] merged
);

    logic [DATA_W-1:0] hi_shift;

    always_comb begin
        hi_shift = hi_data << {lo_len, 3'b000};
        merged   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LW'(i) < lo_len) begin
                merged[8*i +: 8] = lo_data[8*i +: 8];
            end else if (LW'(i) < total_len) begin
                merged[8*i +: 8] = hi_shift[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_read_split.sv
// Splits a read that crosses a cache-line boundary into two TLB pieces and
// reassembles the returned bytes.
//   read_*     : requester side (read_do held until read_done or a fault)
//   tlbread_*  : TLB side, one piece at a time, tlbread_do held while active
//   rd_reset   : pipeline flush; poisons an in-flight access, clears faults
//
// state     | meaning
// ----------+------------------------------------------------
// ST_IDLE   | waiting for read_do; issues first piece combinationally
// ST_SINGLE | access fits in one line, waiting for its piece
// ST_FIRST  | split access, waiting for the low piece
// ST_SECOND | split access, waiting for the piece in the next line
// ST_DONE   | read_done pulse cycle
module memory_read_split
    import memory_read_split_pkg::*;
#(
    parameter int LINE_BYTES = 16,
    parameter int MAX_LEN    = 8,
    localparam int DATA_W    = 8 * MAX_LEN,
    localparam int LW        = $clog2(MAX_LEN) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_reset,
    input  logic              read_do,
    input  logic [1:0]        read_cpl,
    input  logic [31:0]       read_address,
    input  logic [LW-1:0]     read_length,
    input  logic              read_lock,
    input  logic              read_rmw,
    output logic              read_done,
    output logic [DATA_W-1:0] read_data,
    output logic              read_page_fault,
    output logic              read_ac_fault,
    output logic              tlbread_do,
    input  logic              tlbread_done,
    input  logic              tlbread_page_fault,
    input  logic              tlbread_ac_fault,
    input  logic              tlbread_retry,
    output logic [1:0]        tlbread_cpl,
    output logic [31:0]       tlbread_address,
    output logic [LW-1:0]     tlbread_length,
    output logic [LW-1:0]     tlbread_length_full,
    output logic              tlbread_lock,
    output logic              tlbread_rmw,
    input  logic [DATA_W-1:0] tlbread_data
);

    state_t            state_q, state_d;
    logic [LW-1:0]     len1_q, len1_d;
    logic [LW-1:0]     len2_q, len2_d;
    logic [31:0]       addr2_q, addr2_d;
    logic [DATA_W-1:0] buffer_q, buffer_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              read_done_q, read_done_d;
    logic              page_fault_q, page_fault_d;
    logic              ac_fault_q, ac_fault_d;
    logic              reset_waiting_q, reset_waiting_d;
    logic              done_pending_q, done_pending_d;

    logic [LW-1:0]     len1_w;
    logic [LW-1:0]     len2_w;
    logic [31:0]       addr2_w;
    logic              suppress;
    logic [DATA_W-1:0] merge_lo;
    logic [LW-1:0]     merge_total;
    logic [DATA_W-1:0] merged;

    assign len1_w  = LW'(split_len1(read_address, 32'(read_length), 32'(LINE_BYTES)));
    assign len2_w  = read_length - len1_w;
    assign addr2_w = split_addr2(read_address, 32'(LINE_BYTES));

    // In FIRST the merge just trims piece 1 to len1 bytes for the buffer;
    // in SINGLE/SECOND it builds the final result.
    assign merge_lo    = (state_q == ST_SECOND) ? buffer_q : tlbread_data;
    assign merge_total = (state_q == ST_FIRST) ? len1_q : read_length;

    memory_read_merge #(.MAX_LEN(MAX_LEN)) u_merge (
        .lo_data   (merge_lo),
        .lo_len    (len1_q),
        .hi_data   (tlbread_data),
        .total_len (merge_total),
        .merged    (merged)
    );

    assign tlbread_cpl         = read_cpl;
    assign tlbread_lock        = read_lock;
    assign tlbread_rmw         = read_rmw;
    assign tlbread_length_full = read_length;
    assign read_done           = read_done_q;
    assign read_data           = read_data_q;
    assign read_page_fault     = page_fault_q;
    assign read_ac_fault       = ac_fault_q;

    // A flushed access must still drain the TLB, but leaves no trace.
    assign suppress = reset_waiting_q | rd_reset;

    always_comb begin
        state_d         = state_q;
        len1_d          = len1_q;
        len2_d          = len2_q;
        addr2_d         = addr2_q;
        buffer_d        = buffer_q;
        read_data_d     = read_data_q;
        read_done_d     = 1'b0;
        page_fault_d    = page_fault_q & ~rd_reset;
        ac_fault_d      = ac_fault_q & ~rd_reset;
        reset_waiting_d = 1'b0;
        done_pending_d  = (state_q == ST_DONE);
        tlbread_do      = 1'b0;
        tlbread_address = read_address;
        tlbread_length  = len1_q;

        unique case (state_q)
            ST_IDLE: begin
                if (read_do && !done_pending_q && !rd_reset &&
                    !page_fault_q && !ac_fault_q) begin
                    tlbread_do     = 1'b1;
                    tlbread_length = len1_w;
                    len1_d         = len1_w;
                    len2_d         = len2_w;
                    addr2_d        = addr2_w;
                    state_d        = (len2_w == '0) ? ST_SINGLE : ST_FIRST;
                end
            end
            ST_SINGLE, ST_FIRST, ST_SECOND: begin
                tlbread_do      = 1'b1;
                reset_waiting_d = suppress;
                if (state_q == ST_SECOND) begin
                    tlbread_address = addr2_q;
                    tlbread_length  = len2_q;
                end
                if (tlbread_page_fault || tlbread_ac_fault) begin
                    state_d = ST_IDLE;
                    if (!suppress) begin
                        page_fault_d = page_fault_q | tlbread_page_fault;
                        ac_fault_d   = ac_fault_q | tlbread_ac_fault;
                    end
                end else if (tlbread_retry) begin
                    if (reset_waiting_q) begin
                        state_d = ST_IDLE;
                    end
                end else if (tlbread_done) begin
                    if (state_q == ST_FIRST) begin
                        buffer_d = merged;
                        state_d  = ST_SECOND;
                    end else if (suppress) begin
                        state_d = ST_IDLE;
                    end else begin
                        read_data_d = merged;
                        read_done_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            len1_q          <= '0;
            len2_q          <= '0;
            addr2_q         <= '0;
            buffer_q        <= '0;
            read_data_q     <= '0;
            read_done_q     <= 1'b0;
            page_fault_q    <= 1'b0;
            ac_fault_q      <= 1'b0;
            reset_waiting_q <= 1'b0;
            done_pending_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            len1_q          <= len1_d;
            len2_q          <= len2_d;
            addr2_q         <= addr2_d;
            buffer_q        <= buffer_d;
            read_data_q     <= read_data_d;
            read_done_q     <= read_done_d;
            page_fault_q    <= page_fault_d;
            ac_fault_q      <= ac_fault_d;
            reset_waiting_q <= reset_waiting_d;
            done_pending_q  <= done_pending_d;
        end
    end

endmodule

// File: tb/tb_memory_read_split.sv
// Directed bench for memory_read_split (LINE_BYTES=16, MAX_LEN=8).
module tb_memory_read_split;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_reset = 1'b0;
    logic        read_do = 1'b0;
    logic [1:0]  read_cpl = 2'd0;
    logic [31:0] read_address = '0;
    logic [3:0]  read_length = '0;
    logic        read_lock = 1'b0;
    logic        read_rmw = 1'b0;
    logic        read_done;
    logic [63:0] read_data;
    logic        read_page_fault;
    logic        read_ac_fault;
    logic        tlbread_do;
    logic        tlbread_done = 1'b0;
    logic        tlbread_page_fault = 1'b0;
    logic        tlbread_ac_fault = 1'b0;
    logic        tlbread_retry = 1'b0;
    logic [1:0]  tlbread_cpl;
    logic [31:0] tlbread_address;
    logic [3:0]  tlbread_length;
    logic [3:0]  tlbread_length_full;
    logic        tlbread_lock;
    logic        tlbread_rmw;
    logic [63:0] tlbread_data = '0;

    int total = 0;
    int bad   = 0;
    logic [63:0] last_data = '0;

    memory_read_split #(.LINE_BYTES(16), .MAX_LEN(8)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rd_reset            (rd_reset),
        .read_do             (read_do),
        .read_cpl            (read_cpl),
        .read_address        (read_address),
        .read_length         (read_length),
        .read_lock           (read_lock),
        .read_rmw            (read_rmw),
        .read_done           (read_done),
        .read_data           (read_data),
        .read_page_fault     (read_page_fault),
        .read_ac_fault       (read_ac_fault),
        .tlbread_do          (tlbread_do),
        .tlbread_done        (tlbread_done),
        .tlbread_page_fault  (tlbread_page_fault),
        .tlbread_ac_fault    (tlbread_ac_fault),
        .tlbread_retry       (tlbread_retry),
        .tlbread_cpl         (tlbread_cpl),
        .tlbread_address     (tlbread_address),
        .tlbread_length      (tlbread_length),
        .tlbread_length_full (tlbread_length_full),
        .tlbread_lock        (tlbread_lock),
        .tlbread_rmw         (tlbread_rmw),
        .tlbread_data        (tlbread_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [63:0] p1;
        logic [63:0] p2;
        logic        two;
        logic [3:0]  l1;
        logic [31:0] a2;
        logic [3:0]  l2;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Full handshake for one request with the TLB answering one cycle after issue.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        read_do      = 1'b1;
        read_address = v.addr;
        read_length  = v.len;
        read_cpl     = 2'd2;
        read_lock    = 1'b1;
        read_rmw     = 1'b0;
        #1;
        chk("issue_do", 64'(tlbread_do), 64'd1);
        chk("issue_addr", 64'(tlbread_address), 64'(v.addr));
        chk("issue_len", 64'(tlbread_length), 64'(v.l1));
        chk("len_full", 64'(tlbread_length_full), 64'(v.len));
        chk("pass_cpl", 64'({tlbread_cpl, tlbread_lock, tlbread_rmw}), 64'b1010);
        @(negedge clk);
        tlbread_done = 1'b1;
        tlbread_data = v.p1;
        #1;
        chk("p1_do", 64'(tlbread_do), 64'd1);
        chk("p1_addr", 64'(tlbread_address), 64'(v.addr));
        chk("p1_len", 64'(tlbread_length), 64'(v.l1));
        chk("p1_no_done", 64'(read_done), 64'd0);
        if (v.two) begin
            @(negedge clk);
            tlbread_data = v.p2;
            #1;
            chk("p2_addr", 64'(tlbread_address), 64'(v.a2));
            chk("p2_len", 64'(tlbread_length), 64'(v.l2));
            chk("p2_no_done", 64'(read_done), 64'd0);
        end
        @(negedge clk);
        tlbread_done = 1'b0;
        tlbread_data = '0;
        #1;
        chk("done_pulse", 64'(read_done), 64'd1);
        chk("data", read_data, v.exp);
        last_data = v.exp;
        @(negedge clk);
        #1;
        chk("done_once", 64'(read_done), 64'd0);
        chk("no_reissue", 64'(tlbread_do), 64'd0);
        read_do = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] l);
        @(negedge clk);
        read_do      = 1'b1;
        read_address = a;
        read_length  = l;
    endtask

    initial begin
        vecs[0] = '{32'h1000_0004, 4'd4, 64'h5555_5555_DDCC_BBAA, 64'h0, 1'b0, 4'd4, 32'h0, 4'd0, 64'h0000_0000_DDCC_BBAA};
        vecs[1] = '{32'h1000_000E, 4'd4, 64'hEEEE_EEEE_EEEE_BBAA, 64'hFFFF_FFFF_FFFF_DDCC, 1'b1, 4'd2, 32'h1000_0010, 4'd2, 64'h0000_0000_DDCC_BBAA};
        vecs[2] = '{32'hFFFF_FFFC, 4'd8, 64'h9999_9999_4433_2211, 64'h8888_8888_8877_6655, 1'b1, 4'd4, 32'h0000_0000, 4'd4, 64'h8877_6655_4433_2211};
        vecs[3] = '{32'h0000_0020, 4'd8, 64'h0102_0304_0506_0708, 64'h0, 1'b0, 4'd8, 32'h0, 4'd0, 64'h0102_0304_0506_0708};
        vecs[4] = '{32'h0000_123F, 4'd1, 64'hAAAA_AAAA_AAAA_AA5A, 64'h0, 1'b0, 4'd1, 32'h0, 4'd0, 64'h0000_0000_0000_005A};
        vecs[5] = '{32'h0000_004B, 4'd8, 64'h7777_77EE_DDCC_BBAA, 64'h6666_6666_6633_2211, 1'b1, 4'd5, 32'h0000_0050, 4'd3, 64'h3322_11EE_DDCC_BBAA};
        vecs[6] = '{32'h0000_0009, 4'd7, 64'hFF77_6655_4433_2211, 64'h0, 1'b0, 4'd7, 32'h0, 4'd0, 64'h0077_6655_4433_2211};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_done", 64'(read_done), 64'd0);
        chk("rst_data", read_data, 64'd0);
        chk("rst_faults", 64'({read_page_fault, read_ac_fault}), 64'd0);
        chk("rst_tlb_do", 64'(tlbread_do), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // page fault on the second piece
        issue(32'h1000_000E, 4'd4);
        @(negedge clk);
        tlbread_done = 1'b1;
        tlbread_data = 64'h1234;
        @(negedge clk);
        tlbread_done = 1'b0;
        tlbread_page_fault = 1'b1;
        #1;
        chk("pf_addr", 64'(tlbread_address), 64'h1000_0010);
        @(negedge clk);
        tlbread_page_fault = 1'b0;
        #1;
        chk("pf_flag", 64'(read_page_fault), 64'd1);
        chk("pf_no_done", 64'(read_done), 64'd0);
        chk("pf_block", 64'(tlbread_do), 64'd0);
        @(negedge clk);
        #1;
        chk("pf_block2", 64'({tlbread_do, read_done}), 64'd0);
        chk("pf_data_kept", read_data, last_data);
        @(negedge clk);
        rd_reset = 1'b1;
        read_do  = 1'b0;
        @(negedge clk);
        rd_reset = 1'b0;
        #1;
        chk("pf_cleared", 64'(read_page_fault), 64'd0);

        // alignment fault in SINGLE
        issue(32'h0000_0020, 4'd8);
        @(negedge clk);
        tlbread_ac_fault = 1'b1;
        @(negedge clk);
        tlbread_ac_fault = 1'b0;
        #1;
        chk("ac_flags", 64'({read_ac_fault, read_page_fault, read_done}), 64'b100);
        @(negedge clk);
        rd_reset = 1'b1;
        read_do  = 1'b0;
        @(negedge clk);
        rd_reset = 1'b0;
        #1;
        chk("ac_cleared", 64'(read_ac_fault), 64'd0);

        // flush in FIRST; access drains two pieces silently
        issue(32'h1000_000E, 4'd4);
        @(negedge clk);
        rd_reset = 1'b1;
        read_do  = 1'b0;
        @(negedge clk);
        rd_reset = 1'b0;
        tlbread_done = 1'b1;
        tlbread_data = 64'h5151;
        #1;
        chk("flush_still_do", 64'(tlbread_do), 64'd1);
        @(negedge clk);
        tlbread_data = 64'h7373;
        #1;
        chk("flush_p2_addr", 64'(tlbread_address), 64'h1000_0010);
        @(negedge clk);
        tlbread_done = 1'b0;
        #1;
        chk("flush_no_done", 64'({read_done, tlbread_do}), 64'd0);
        @(negedge clk);
        #1;
        chk("flush_no_done2", 64'(read_done), 64'd0);
        chk("flush_data_kept", read_data, last_data);
        run_vec(vecs[1]);

        // retry in SINGLE replays the same piece
        issue(32'h0000_0020, 4'd8);
        @(negedge clk);
        tlbread_retry = 1'b1;
        @(negedge clk);
        tlbread_retry = 1'b0;
        #1;
        chk("retry_do", 64'(tlbread_do), 64'd1);
        chk("retry_addr", 64'(tlbread_address), 64'h0000_0020);
        chk("retry_len", 64'(tlbread_length), 64'd8);
        chk("retry_no_done", 64'(read_done), 64'd0);
        tlbread_done = 1'b1;
        tlbread_data = 64'hCAFE_F00D_0BAD_BEEF;
        @(negedge clk);
        tlbread_done = 1'b0;
        #1;
        chk("retry_done", 64'(read_done), 64'd1);
        chk("retry_data", read_data, 64'hCAFE_F00D_0BAD_BEEF);
        last_data = 64'hCAFE_F00D_0BAD_BEEF;
        @(negedge clk);
        read_do = 1'b0;
        #1;
        chk("retry_done_once", 64'(read_done), 64'd0);

        // flush coincident with the final piece
        @(negedge clk);
        issue(32'h0000_0020, 4'd8);
        @(negedge clk);
        tlbread_done = 1'b1;
        tlbread_data = 64'h1111_2222_3333_4444;
        rd_reset = 1'b1;
        @(negedge clk);
        tlbread_done = 1'b0;
        rd_reset = 1'b0;
        read_do = 1'b0;
        #1;
        chk("late_flush_no_done", 64'(read_done), 64'd0);
        chk("late_flush_data", read_data, last_data);
        @(negedge clk);
        #1;
        chk("late_flush_idle", 64'({read_done, tlbread_do}), 64'd0);
        run_vec(vecs[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
